// File: rtl/frame_pkg.sv
// Shared definitions for the recursion-frame store: widths, STATE field
// layout, patch-mask bit positions and the packed STATE view.
package frame_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned STATE_W  = 18;
  localparam int unsigned IR_W     = 32;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned PAR_W    = 12;

  // STATE bit offsets
  localparam int unsigned POS_LSB  = 13;
  localparam int unsigned PAR_LSB  = 1;
  localparam int unsigned DONE_BIT = 0;

  // ran_state_fmask bit indices {pos,parent,done}
  localparam int unsigned FM_POS   = 2;
  localparam int unsigned FM_PAR   = 1;
  localparam int unsigned FM_DONE  = 0;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [PAR_W-1:0] parent;
    logic             done;
  } frame_state_t;

endpackage

// File: rtl/frame_field_ram.sv
// One field array of the frame store: single write port, registered read
// port, write-first on an address match.
// Ports: clk; i_we/i_waddr/i_wdata write; i_re/i_raddr read request;
//        o_rdata read data, one cycle after i_re.
module frame_field_ram #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage and read register; same-address write is forwarded to the read
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/recur_frame_store.sv
// Recursion-frame memory fed by write-back: appends frames at a tail
// pointer, patches STATE fields / INEXRECUR words of live frames, and serves
// a registered read port to fetch. Reports occupancy, full and overflow.
// Ports: clk, rst_n (sync, active-low); init_i/root_i start a search;
//        seq_* append port; ran_* patch ports; rd_en_i/rd_addr_i read in;
//        rd_state_o/rd_InexRecur_o/rd_valid_o read out; tail_o, full_o,
//        overflow_o status.
module recur_frame_store
  import frame_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic [IR_W-1:0]   root_i,
  input  logic              seq_we_state,
  input  logic              seq_we_InexRecur,
  input  logic [STATE_W-1:0] seq_w_data_state,
  input  logic [IR_W-1:0]   seq_w_data_InexRecur,
  input  logic              ran_we_state,
  input  logic [2:0]        ran_state_fmask,
  input  logic [STATE_W-1:0] ran_w_data_state,
  input  logic [ADDR_W-1:0] ran_w_addr_state,
  input  logic              ran_we_InexRecur,
  input  logic [IR_W-1:0]   ran_w_data_InexRecur,
  input  logic [ADDR_W-1:0] ran_w_addr_InexRecur,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [STATE_W-1:0] rd_state_o,
  output logic [IR_W-1:0]   rd_InexRecur_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] tail_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW     = ADDR_W + 1;

  // Tail carries one extra bit so that tail == DEPTH is representable
  logic [TW-1:0] r_tail;
  logic          r_overflow;
  logic          r_rd_valid;
  logic          r_rd_ok;

  logic          w_full, w_app_req, w_app_ok, w_app_st, w_app_ir;
  logic          w_pst_ok, w_pir_ok, w_coll, w_rd_ok;
  logic [TW-1:0] w_tail_nxt;
  logic [ADDR_W-1:0] w_tail_a;
  frame_state_t  w_ps, w_as, w_ms, w_st_wdata, w_rd_st;
  logic [ADDR_W-1:0] w_st_addr, w_ir_addr;
  logic [IR_W-1:0]   w_ir_wdata, w_rd_ir;
  logic [2:0]    w_st_we;
  logic          w_ir_we;

  // Write arbitration: init > append > patch. An append owns every array it
  // writes; write-back never pairs it with a patch to a different frame.
  always_comb begin
    w_full    = (r_tail == TW'(DEPTH));
    w_tail_a  = r_tail[ADDR_W-1:0];
    w_app_req = seq_we_state | seq_we_InexRecur;
    w_app_ok  = w_app_req & ~w_full & ~init_i;
    w_app_st  = w_app_ok & seq_we_state;
    w_app_ir  = w_app_ok & seq_we_InexRecur;
    w_ps      = frame_state_t'(ran_w_data_state);
    w_as      = frame_state_t'(seq_w_data_state);
    w_coll    = w_app_st & (ran_w_addr_state == w_tail_a);
    // STATE patch targets a live frame, or the frame being appended now
    w_pst_ok  = ~init_i & ran_we_state & (ran_state_fmask != 3'b000) &
                (({1'b0, ran_w_addr_state} < r_tail) | w_coll);
    w_pir_ok  = ~init_i & ran_we_InexRecur & ({1'b0, ran_w_addr_InexRecur} < r_tail);

    // Append value with masked patch fields merged over it
    w_ms        = w_as;
    if (w_pst_ok && w_coll) begin
      if (ran_state_fmask[FM_POS])  w_ms.pos    = w_ps.pos;
      if (ran_state_fmask[FM_PAR])  w_ms.parent = w_ps.parent;
      if (ran_state_fmask[FM_DONE]) w_ms.done   = w_ps.done;
    end

    w_st_we    = '0;
    w_st_addr  = ran_w_addr_state;
    w_st_wdata = w_ps;
    if (init_i) begin
      w_st_we    = 3'b111;
      w_st_addr  = '0;
      w_st_wdata = '0;
    end else if (w_app_st) begin
      w_st_we    = 3'b111;
      w_st_addr  = w_tail_a;
      w_st_wdata = w_ms;
    end else if (w_pst_ok) begin
      w_st_we    = ran_state_fmask;
    end

    w_ir_we    = init_i | w_app_ir | w_pir_ok;
    w_ir_addr  = ran_w_addr_InexRecur;
    w_ir_wdata = ran_w_data_InexRecur;
    if (init_i) begin
      w_ir_addr  = '0;
      w_ir_wdata = root_i;
    end else if (w_app_ir) begin
      w_ir_addr  = w_tail_a;
      w_ir_wdata = seq_w_data_InexRecur;
    end

    if (init_i)        w_tail_nxt = TW'(1);
    else if (w_app_ok) w_tail_nxt = r_tail + TW'(1);
    else               w_tail_nxt = r_tail;

    // In-range check uses the post-write tail so a same-cycle append is readable
    w_rd_ok = rd_en_i & ({1'b0, rd_addr_i} < w_tail_nxt);
  end

  // Status and read-qualifier registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tail     <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_tail     <= w_tail_nxt;
      r_overflow <= init_i ? 1'b0 : (r_overflow | (w_app_req & w_full));
      r_rd_valid <= rd_en_i;
      r_rd_ok    <= w_rd_ok;
    end
  end

  frame_field_ram #(.WIDTH(POS_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_pos (
    .clk(clk), .i_we(w_st_we[FM_POS] & rst_n), .i_waddr(w_st_addr[RAM_AW-1:0]),
    .i_wdata(w_st_wdata.pos), .i_re(rd_en_i), .i_raddr(rd_addr_i[RAM_AW-1:0]),
    .o_rdata(w_rd_st.pos));

  frame_field_ram #(.WIDTH(PAR_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_parent (
    .clk(clk), .i_we(w_st_we[FM_PAR] & rst_n), .i_waddr(w_st_addr[RAM_AW-1:0]),
    .i_wdata(w_st_wdata.parent), .i_re(rd_en_i), .i_raddr(rd_addr_i[RAM_AW-1:0]),
    .o_rdata(w_rd_st.parent));

  frame_field_ram #(.WIDTH(1), .DEPTH(DEPTH), .AW(RAM_AW)) u_done (
    .clk(clk), .i_we(w_st_we[FM_DONE] & rst_n), .i_waddr(w_st_addr[RAM_AW-1:0]),
    .i_wdata(w_st_wdata.done), .i_re(rd_en_i), .i_raddr(rd_addr_i[RAM_AW-1:0]),
    .o_rdata(w_rd_st.done));

  frame_field_ram #(.WIDTH(IR_W), .DEPTH(DEPTH), .AW(RAM_AW)) u_inexrecur (
    .clk(clk), .i_we(w_ir_we & rst_n), .i_waddr(w_ir_addr[RAM_AW-1:0]),
    .i_wdata(w_ir_wdata), .i_re(rd_en_i), .i_raddr(rd_addr_i[RAM_AW-1:0]),
    .o_rdata(w_rd_ir));

  // Out-of-range or idle reads present zero
  assign rd_state_o     = r_rd_ok ? STATE_W'(w_rd_st) : '0;
  assign rd_InexRecur_o = r_rd_ok ? w_rd_ir : '0;
  assign rd_valid_o     = r_rd_valid;
  // Wraps to 0 only when DEPTH == 2**ADDR_W and full; full_o disambiguates
  assign tail_o         = r_tail[ADDR_W-1:0];
  assign full_o         = w_full;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_recur_frame_store.sv
module tb_recur_frame_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_i;
  logic [31:0] root_i;
  logic        seq_we_state, seq_we_InexRecur;
  logic [17:0] seq_w_data_state;
  logic [31:0] seq_w_data_InexRecur;
  logic        ran_we_state;
  logic [2:0]  ran_state_fmask;
  logic [17:0] ran_w_data_state;
  logic [11:0] ran_w_addr_state;
  logic        ran_we_InexRecur;
  logic [31:0] ran_w_data_InexRecur;
  logic [11:0] ran_w_addr_InexRecur;
  logic        rd_en_i;
  logic [11:0] rd_addr_i;
  logic [17:0] rd_state_o;
  logic [31:0] rd_InexRecur_o;
  logic        rd_valid_o;
  logic [11:0] tail_o;
  logic        full_o, overflow_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  recur_frame_store #(.ADDR_W(12), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_i(init_i), .root_i(root_i),
    .seq_we_state(seq_we_state), .seq_we_InexRecur(seq_we_InexRecur),
    .seq_w_data_state(seq_w_data_state), .seq_w_data_InexRecur(seq_w_data_InexRecur),
    .ran_we_state(ran_we_state), .ran_state_fmask(ran_state_fmask),
    .ran_w_data_state(ran_w_data_state), .ran_w_addr_state(ran_w_addr_state),
    .ran_we_InexRecur(ran_we_InexRecur), .ran_w_data_InexRecur(ran_w_data_InexRecur),
    .ran_w_addr_InexRecur(ran_w_addr_InexRecur),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_state_o(rd_state_o), .rd_InexRecur_o(rd_InexRecur_o), .rd_valid_o(rd_valid_o),
    .tail_o(tail_o), .full_o(full_o), .overflow_o(overflow_o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_i = 0; root_i = '0;
    seq_we_state = 0; seq_we_InexRecur = 0; seq_w_data_state = '0; seq_w_data_InexRecur = '0;
    ran_we_state = 0; ran_state_fmask = '0; ran_w_data_state = '0; ran_w_addr_state = '0;
    ran_we_InexRecur = 0; ran_w_data_InexRecur = '0; ran_w_addr_InexRecur = '0;
    rd_en_i = 0; rd_addr_i = '0;
  endtask

  task automatic read_frame(input logic [11:0] a);
    rd_en_i = 1; rd_addr_i = a;
    tick();
    rd_en_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    checks++; if (tail_o !== 12'd0) begin failures++; $display("FAIL reset_tail got=%0d exp=0", tail_o); end
    checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid_o); end
    checks++; if (rd_state_o !== 18'd0) begin failures++; $display("FAIL reset_state got=%h exp=0", rd_state_o); end
    checks++; if (rd_InexRecur_o !== 32'd0) begin failures++; $display("FAIL reset_ir got=%h exp=0", rd_InexRecur_o); end
    rst_n = 1;
  endtask

  task automatic test_init();
    init_i = 1; root_i = 32'h0A14_0305;
    tick();
    init_i = 0;
    read_frame(12'd0);
    checks++; if (rd_InexRecur_o !== 32'h0A14_0305) begin failures++; $display("FAIL init_ir got=%h exp=0a140305", rd_InexRecur_o); end
    checks++; if (rd_state_o !== 18'd0) begin failures++; $display("FAIL init_state got=%h exp=0", rd_state_o); end
    checks++; if (rd_valid_o !== 1'b1) begin failures++; $display("FAIL init_valid got=%b exp=1", rd_valid_o); end
    checks++; if (tail_o !== 12'd1) begin failures++; $display("FAIL init_tail got=%0d exp=1", tail_o); end
  endtask

  task automatic test_append();
    for (int k = 1; k <= 3; k++) begin
      seq_we_state = 1; seq_we_InexRecur = 1;
      seq_w_data_state = 18'(k); seq_w_data_InexRecur = 32'(k);
      tick();
    end
    seq_we_state = 0; seq_we_InexRecur = 0;
    checks++; if (tail_o !== 12'd4) begin failures++; $display("FAIL append_tail got=%0d exp=4", tail_o); end
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL append_full got=%b exp=1", full_o); end
    for (int k = 1; k <= 3; k++) begin
      read_frame(12'(k));
      checks++; if (rd_state_o !== 18'(k)) begin failures++; $display("FAIL append_rd_state%0d got=%h exp=%h", k, rd_state_o, 18'(k)); end
      checks++; if (rd_InexRecur_o !== 32'(k)) begin failures++; $display("FAIL append_rd_ir%0d got=%h exp=%h", k, rd_InexRecur_o, 32'(k)); end
    end
    tick();
    checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL rd_valid_drop got=%b exp=0", rd_valid_o); end
  endtask

  task automatic test_patch_state();
    // pos only: addr1 {0,0,1} -> {7,0,1}
    ran_we_state = 1; ran_state_fmask = 3'b100; ran_w_addr_state = 12'd1; ran_w_data_state = 18'h0FFFE;
    tick();
    ran_we_state = 0;
    read_frame(12'd1);
    checks++; if (rd_state_o !== 18'h0E001) begin failures++; $display("FAIL patch_pos got=%h exp=0e001", rd_state_o); end
    // done only, with a same-cycle read (write-first): {7,0,1} -> {7,0,0}
    ran_we_state = 1; ran_state_fmask = 3'b001; ran_w_addr_state = 12'd1; ran_w_data_state = 18'h3FFFE;
    rd_en_i = 1; rd_addr_i = 12'd1;
    tick();
    ran_we_state = 0; rd_en_i = 0;
    checks++; if (rd_state_o !== 18'h0E000) begin failures++; $display("FAIL patch_done_wf got=%h exp=0e000", rd_state_o); end
    // done only on addr2 {0,1,0} -> {0,1,1}
    ran_we_state = 1; ran_state_fmask = 3'b001; ran_w_addr_state = 12'd2; ran_w_data_state = 18'h3FFFF;
    tick();
    ran_we_state = 0;
    read_frame(12'd2);
    checks++; if (rd_state_o !== 18'h00003) begin failures++; $display("FAIL patch_done got=%h exp=00003", rd_state_o); end
    // zero mask is a no-op
    ran_we_state = 1; ran_state_fmask = 3'b000; ran_w_addr_state = 12'd2; ran_w_data_state = 18'h3FFFF;
    tick();
    ran_we_state = 0;
    read_frame(12'd2);
    checks++; if (rd_state_o !== 18'h00003) begin failures++; $display("FAIL patch_nomask got=%h exp=00003", rd_state_o); end
  endtask

  task automatic test_patch_ir();
    ran_we_InexRecur = 1; ran_w_addr_InexRecur = 12'd3; ran_w_data_InexRecur = 32'hDEAD_BEEF;
    tick();
    ran_we_InexRecur = 0;
    read_frame(12'd3);
    checks++; if (rd_InexRecur_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL patch_ir got=%h exp=deadbeef", rd_InexRecur_o); end
    read_frame(12'd5);
    checks++; if (rd_InexRecur_o !== 32'd0) begin failures++; $display("FAIL oob_ir got=%h exp=0", rd_InexRecur_o); end
    checks++; if (rd_valid_o !== 1'b1) begin failures++; $display("FAIL oob_valid got=%b exp=1", rd_valid_o); end
  endtask

  task automatic test_overflow();
    seq_we_state = 1; seq_w_data_state = 18'h00015;
    tick();
    seq_we_state = 0;
    checks++; if (tail_o !== 12'd4) begin failures++; $display("FAIL ovf_tail got=%0d exp=4", tail_o); end
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full_o); end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    read_frame(12'd3);
    checks++; if (rd_state_o !== 18'd3) begin failures++; $display("FAIL ovf_nowrite got=%h exp=3", rd_state_o); end
    init_i = 1; root_i = 32'h1111_2222;
    tick();
    init_i = 0;
    checks++; if (tail_o !== 12'd1) begin failures++; $display("FAIL reinit_tail got=%0d exp=1", tail_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reinit_ovf got=%b exp=0", overflow_o); end
    checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reinit_full got=%b exp=0", full_o); end
  endtask

  task automatic test_ignored_patch();
    // tail=1: overwrite of frame1 is ignored, then a STATE-only append leaves its stale INEXRECUR
    ran_we_InexRecur = 1; ran_w_addr_InexRecur = 12'd1; ran_w_data_InexRecur = 32'h1234_5678;
    tick();
    ran_we_InexRecur = 0;
    seq_we_state = 1; seq_w_data_state = 18'h00010;
    tick();
    seq_we_state = 0;
    read_frame(12'd1);
    checks++; if (rd_state_o !== 18'h00010) begin failures++; $display("FAIL ign_state got=%h exp=00010", rd_state_o); end
    checks++; if (rd_InexRecur_o !== 32'd1) begin failures++; $display("FAIL ign_ir got=%h exp=00000001", rd_InexRecur_o); end
  endtask

  task automatic test_collision();
    seq_we_state = 1; seq_we_InexRecur = 1;
    seq_w_data_state = 18'h06002; seq_w_data_InexRecur = 32'hCAFE_0002;
    ran_we_state = 1; ran_state_fmask = 3'b001; ran_w_addr_state = 12'd2; ran_w_data_state = 18'h00001;
    rd_en_i = 1; rd_addr_i = 12'd2;
    tick();
    idle_inputs();
    checks++; if (tail_o !== 12'd3) begin failures++; $display("FAIL coll_tail got=%0d exp=3", tail_o); end
    checks++; if (rd_state_o !== 18'h06003) begin failures++; $display("FAIL coll_state got=%h exp=06003", rd_state_o); end
    checks++; if (rd_InexRecur_o !== 32'hCAFE_0002) begin failures++; $display("FAIL coll_ir got=%h exp=cafe0002", rd_InexRecur_o); end
  endtask

  task automatic test_reset_mid();
    seq_we_state = 1; seq_we_InexRecur = 1; seq_w_data_state = 18'h00007; seq_w_data_InexRecur = 32'h7;
    rd_en_i = 1; rd_addr_i = 12'd0;
    rst_n = 0;
    tick();
    idle_inputs();
    checks++; if (tail_o !== 12'd0) begin failures++; $display("FAIL rstmid_tail got=%0d exp=0", tail_o); end
    checks++; if (rd_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rd_valid_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b exp=0", overflow_o); end
    checks++; if (rd_InexRecur_o !== 32'd0) begin failures++; $display("FAIL rstmid_ir got=%h exp=0", rd_InexRecur_o); end
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_append();
    test_patch_state();
    test_patch_ir();
    test_overflow();
    test_ignored_patch();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
